// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: memory-side responder for LC-3 effective addresses.
// It latches an address into MAR and, for writes, the write data into MDR.
// It then runs one read or write against a variable-latency word memory
// that uses an ack handshake. Read data is returned through MDR.
//
// Ports
//   clk, reset_n          clock (rising edge) and async active-low reset
//   req, we               start access / write select, sampled in IDLE only
//   addr_in, wdata        effective address and write data, latched on accept
//   busy, done, err       status: in ACCESS / one-cycle completion / sticky timeout
//   rdata, mar            MDR and MAR contents
//   mem_addr, mem_wdata   memory address (= MAR) and write data (= MDR)
//   mem_en, mem_we        memory request and write strobe, active in ACCESS only
//   mem_rdata, mem_ack    memory read data and one-cycle completion
module lc3_mem_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} stateT;

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] marQ, marD;
  logic [DATA_W-1:0] mdrQ, mdrD;
  logic              weQ, weD;
  logic              errQ, errD;
  logic [CntW-1:0]   cntQ, cntD;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= StIdle;
      marQ   <= '0;
      mdrQ   <= '0;
      weQ    <= 1'b0;
      errQ   <= 1'b0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      marQ   <= marD;
      mdrQ   <= mdrD;
      weQ    <= weD;
      errQ   <= errD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD = stateQ;
    marD   = marQ;
    mdrD   = mdrQ;
    weD    = weQ;
    errD   = errQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (req) begin
          marD   = addr_in;
          weD    = we;
          errD   = 1'b0;
          cntD   = '0;
          if (we) mdrD = wdata;
          stateD = StAccess;
        end
      end
      StAccess: begin
        // Saturate so the counter never wraps.
        if (cntQ != CntLast) cntD = cntQ + CntW'(1);
        // An ack takes priority over a timeout in the same cycle.
        if (mem_ack) begin
          if (!weQ) mdrD = mem_rdata;
          stateD = StDone;
        end else if (cntQ == CntLast) begin
          errD   = 1'b1;
          stateD = StDone;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Outputs decode the state directly, so an async reset drops them at once.
  always_comb begin
    busy      = (stateQ == StAccess);
    done      = (stateQ == StDone);
    mem_en    = (stateQ == StAccess);
    mem_we    = (stateQ == StAccess) && weQ;
    err       = errQ;
    rdata     = mdrQ;
    mar       = marQ;
    mem_addr  = marQ;
    mem_wdata = mdrQ;
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl. Inputs are driven 1 time
// unit after a rising edge, and outputs are sampled at the same point.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we;
  logic [15:0] addr_in, wdata;
  logic        busy, done, err;
  logic [15:0] rdata, mar, mem_addr, mem_wdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  int enCycles;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(
    .DATA_W (16),
    .ADDR_W (16),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .we       (we),
    .addr_in  (addr_in),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mar      (mar),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; addr_in = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    checkEq("rst_busy", busy, 0);
    checkEq("rst_done", done, 0);
    checkEq("rst_mem_en", mem_en, 0);
    checkEq("rst_mar", mar, 0);
    checkEq("rst_rdata", rdata, 0);
    reset_n = 1'b1;
    tick();

    // Read with the ack in the first ACCESS cycle.
    req = 1'b1; we = 1'b0; addr_in = 16'h3000;
    tick();
    req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF; addr_in = 16'h0BAD;
    checkEq("rd_busy", busy, 1);
    checkEq("rd_mem_en", mem_en, 1);
    checkEq("rd_mem_we", mem_we, 0);
    checkEq("rd_mem_addr", mem_addr, 16'h3000);
    checkEq("rd_done_early", done, 0);
    tick();
    mem_ack = 1'b0;
    checkEq("rd_done", done, 1);
    checkEq("rd_busy_done", busy, 0);
    checkEq("rd_rdata", rdata, 16'hBEEF);
    checkEq("rd_err", err, 0);
    tick();
    checkEq("rd_done_pulse", done, 0);

    // Write acked in its third ACCESS cycle.
    req = 1'b1; we = 1'b1; addr_in = 16'h4010; wdata = 16'h1234;
    tick();
    req = 1'b0; we = 1'b0; wdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      checkEq("wr_mem_we", mem_we, 1);
      checkEq("wr_mem_wdata", mem_wdata, 16'h1234);
      checkEq("wr_done_early", done, 0);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    checkEq("wr_done", done, 1);
    checkEq("wr_mem_we_off", mem_we, 0);
    checkEq("wr_rdata", rdata, 16'h1234);
    checkEq("wr_mar", mar, 16'h4010);
    tick();

    // Read that never gets an ack and times out.
    req = 1'b1; we = 1'b0; addr_in = 16'h5000; mem_rdata = 16'h5555;
    tick();
    req = 1'b0;
    enCycles = 0;
    while (mem_en && enCycles < 40) begin
      enCycles++;
      tick();
    end
    checkEq("to_en_cycles", enCycles, 16);
    checkEq("to_done", done, 1);
    checkEq("to_err", err, 1);
    checkEq("to_rdata", rdata, 16'h1234);
    tick();
    checkEq("to_err_sticky", err, 1);

    // Ack arriving in the timeout cycle wins, and the accept clears err.
    req = 1'b1; we = 1'b0; addr_in = 16'h6000;
    tick();
    req = 1'b0;
    checkEq("ack16_err_clr", err, 0);
    for (int i = 0; i < 15; i++) tick();
    checkEq("ack16_busy", busy, 1);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    checkEq("ack16_done", done, 1);
    checkEq("ack16_err", err, 0);
    checkEq("ack16_rdata", rdata, 16'hCAFE);
    tick();

    // req is held high through DONE, so a second access starts from IDLE.
    req = 1'b1; we = 1'b0; addr_in = 16'h7000;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h1111; addr_in = 16'h7777;
    tick();
    mem_ack = 1'b0; addr_in = 16'h8000;
    checkEq("hold_done", done, 1);
    checkEq("hold_rdata", rdata, 16'h1111);
    checkEq("hold_mar", mar, 16'h7000);
    tick();
    checkEq("hold_idle_busy", busy, 0);
    checkEq("hold_idle_done", done, 0);
    tick();
    req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222;
    checkEq("hold_2nd_busy", busy, 1);
    checkEq("hold_2nd_mar", mar, 16'h8000);
    tick();
    mem_ack = 1'b0;
    checkEq("hold_2nd_done", done, 1);
    checkEq("hold_2nd_rdata", rdata, 16'h2222);
    tick();

    // A mem_ack pulse in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    checkEq("idle_ack_busy", busy, 0);
    checkEq("idle_ack_done", done, 0);
    checkEq("idle_ack_rdata", rdata, 16'h2222);
    tick();

    // Reset asserted in the middle of a write access.
    req = 1'b1; we = 1'b1; addr_in = 16'h9000; wdata = 16'hABCD;
    tick();
    req = 1'b0; we = 1'b0;
    checkEq("mid_mem_we", mem_we, 1);
    reset_n = 1'b0;
    #1;
    checkEq("mid_rst_mem_en", mem_en, 0);
    checkEq("mid_rst_mem_we", mem_we, 0);
    checkEq("mid_rst_busy", busy, 0);
    checkEq("mid_rst_mar", mar, 0);
    checkEq("mid_rst_rdata", rdata, 0);
    checkEq("mid_rst_err", err, 0);
    tick();
    checkEq("mid_rst_no_done", done, 0);
    reset_n = 1'b1;
    tick();
    checkEq("post_rst_done", done, 0);
    checkEq("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
